// File: rtl/freq_meter_pkg.sv
// ============================================================================
// Module : freq_meter_pkg
// Brief  : Shared state encoding and saturating-increment helper for freq_meter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } fm_state_t;

  // Increment v, clamping at the all-ones value of a w-bit counter (w <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/freq_meter_sync_rise_det.sv
// ============================================================================
// Module : sync_rise_det
// Brief  : Two-flop synchroniser plus delay flop; one-cycle rising-edge strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q_sync,
  output logic rise
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign q_sync = r_sync;
  assign rise   = r_sync & ~r_dly;

endmodule

`default_nettype wire

// File: rtl/freq_meter.sv
// ============================================================================
// Module : freq_meter
// Brief  : Measures sig_in period in clk cycles, averaged over 2^AVG_LOG2 periods.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 100000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic             timeout,
  output logic [CNT_W-1:0] period_cycles
);

  localparam logic [CNT_W-1:0]    C_TMO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [AVG_LOG2-1:0] C_EDGE_LAST = '1;

  fm_state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_acc, w_acc_nxt;
  logic [CNT_W-1:0]    r_tmo_cnt, w_tmo_nxt;
  logic [CNT_W-1:0]    r_period, w_period_nxt;
  logic [AVG_LOG2-1:0] r_edges, w_edges_nxt;
  logic                r_tmo_flag, w_tmo_flag_nxt;
  logic                w_sig_sync, w_rise_det, w_rise;
  logic                w_tmo_hit, w_last_rise;
  logic [CNT_W-1:0]    w_acc_inc;

  sync_rise_det u_sync (
    .clk    (clk),
    .rst    (rst),
    .d      (sig_in),
    .q_sync (w_sig_sync),
    .rise   (w_rise_det)
  );

  assign w_rise      = w_rise_det & w_sig_sync;
  assign w_tmo_hit   = (r_tmo_cnt == C_TMO_LAST);
  assign w_last_rise = w_rise && (r_edges == C_EDGE_LAST);
  assign w_acc_inc   = CNT_W'(sat_inc(64'(r_acc), CNT_W));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_acc      <= '0;
      r_tmo_cnt  <= '0;
      r_period   <= '0;
      r_edges    <= '0;
      r_tmo_flag <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_tmo_cnt  <= w_tmo_nxt;
      r_period   <= w_period_nxt;
      r_edges    <= w_edges_nxt;
      r_tmo_flag <= w_tmo_flag_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_acc_nxt      = r_acc;
    w_tmo_nxt      = r_tmo_cnt;
    w_period_nxt   = r_period;
    w_edges_nxt    = r_edges;
    w_tmo_flag_nxt = r_tmo_flag;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_ARM;
          w_tmo_nxt   = '0;
        end
      end
      ST_ARM: begin
        // A rise on the final timeout cycle still starts the measurement.
        if (w_rise) begin
          w_state_nxt = ST_MEASURE;
          w_acc_nxt   = CNT_W'(1);
          w_edges_nxt = '0;
        end else if (w_tmo_hit) begin
          w_state_nxt    = ST_DONE;
          w_tmo_flag_nxt = 1'b1;
          w_period_nxt   = '1;
        end else begin
          w_tmo_nxt = r_tmo_cnt + CNT_W'(1);
        end
      end
      ST_MEASURE: begin
        w_acc_nxt = w_acc_inc;
        w_tmo_nxt = r_tmo_cnt + CNT_W'(1);
        if (w_rise) begin
          w_edges_nxt = r_edges + AVG_LOG2'(1);
        end
        if (w_last_rise) begin
          w_state_nxt    = ST_DONE;
          w_period_nxt   = r_acc >> AVG_LOG2;
          w_tmo_flag_nxt = 1'b0;
        end else if (w_tmo_hit) begin
          w_state_nxt    = ST_DONE;
          w_tmo_flag_nxt = 1'b1;
          w_period_nxt   = '1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign busy          = (r_state == ST_ARM) || (r_state == ST_MEASURE);
  assign valid         = (r_state == ST_DONE);
  assign timeout       = valid & r_tmo_flag;
  assign period_cycles = r_period;

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
// ============================================================================
// Module : tb_freq_meter
// Brief  : Directed self-checking bench for freq_meter (TIMEOUT=1000, N=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_freq_meter;

  localparam int CNT_W    = 32;
  localparam int AVG_LOG2 = 2;
  localparam int TIMEOUT  = 1000;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic             start;
  logic             busy;
  logic             valid;
  logic             timeout;
  logic [CNT_W-1:0] period_cycles;

  int   vectors     = 0;
  int   miscompares = 0;
  int   hi = 50, lo = 50, ph = 0;
  bit   gen_en    = 1'b0;
  logic gen_level = 1'b0;
  int   cyc;

  freq_meter #(
    .CNT_W    (CNT_W),
    .AVG_LOG2 (AVG_LOG2),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sig_in        (sig_in),
    .start         (start),
    .busy          (busy),
    .valid         (valid),
    .timeout       (timeout),
    .period_cycles (period_cycles)
  );

  always #5 clk = ~clk;

  // Square-wave source: high for hi cycles, low for lo cycles, changes 2 ns after posedge.
  initial begin
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (gen_en) begin
        if (ph >= hi + lo - 1) ph = 0;
        else ph++;
        sig_in = (ph < hi);
      end else begin
        sig_in = gen_level;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (valid !== 1'b1 && n < limit);
  endtask

  task automatic run_meas(input string tag, input logic [31:0] exp_p, input logic exp_t);
    int n;
    pulse_start();
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_valid(1500, n);
    check({tag, "_valid"}, 32'(valid), 32'd1);
    check({tag, "_period"}, period_cycles, exp_p);
    check({tag, "_timeout"}, 32'(timeout), 32'(exp_t));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #3 rst = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_valid",   32'(valid),   32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_period",  period_cycles, 32'd0);
    rst = 1'b1;

    // T1: period 100
    hi = 50; lo = 50; gen_en = 1'b1;
    repeat (250) @(negedge clk);
    run_meas("t1", 32'd100, 1'b0);
    check("t1_busy_done", 32'(busy), 32'd0);

    // T4: start during MEASURE is ignored; start in DONE drops valid and remeasures
    pulse_start();
    repeat (150) @(negedge clk);
    check("t4_busy_mid", 32'(busy), 32'd1);
    pulse_start();
    wait_valid(1500, cyc);
    check("t4_valid", 32'(valid), 32'd1);
    check("t4_period", period_cycles, 32'd100);
    check("t4_timeout", 32'(timeout), 32'd0);
    hi = 30; lo = 30;
    repeat (200) @(negedge clk);
    check("t4_hold_valid", 32'(valid), 32'd1);
    check("t4_hold_period", period_cycles, 32'd100);
    pulse_start();
    check("t4_valid_drop", 32'(valid), 32'd0);
    check("t4_busy_rearm", 32'(busy), 32'd1);
    wait_valid(1500, cyc);
    check("t4_new_period", period_cycles, 32'd60);

    // T2: odd duty and minimum periods
    hi = 18; lo = 19;
    repeat (150) @(negedge clk);
    run_meas("t2_p37", 32'd37, 1'b0);
    hi = 1; lo = 1;
    repeat (20) @(negedge clk);
    run_meas("t2_p2", 32'd2, 1'b0);
    hi = 1; lo = 2;
    repeat (20) @(negedge clk);
    run_meas("t2_p3", 32'd3, 1'b0);

    // T3: no edges -> timeout exactly TIMEOUT cycles after start is sampled
    gen_en = 1'b0; gen_level = 1'b0;
    repeat (10) @(negedge clk);
    pulse_start();
    check("t3_busy", 32'(busy), 32'd1);
    wait_valid(1500, cyc);
    check("t3_valid", 32'(valid), 32'd1);
    check("t3_cycles", 32'(cyc), 32'd1000);
    check("t3_timeout", 32'(timeout), 32'd1);
    check("t3_period", period_cycles, 32'hFFFF_FFFF);

    // T5: asynchronous reset mid-measurement
    hi = 50; lo = 50; ph = 0; gen_en = 1'b1;
    repeat (300) @(negedge clk);
    pulse_start();
    repeat (250) @(posedge clk);
    check("t5_busy_pre", 32'(busy), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_valid", 32'(valid), 32'd0);
    check("t5_timeout", 32'(timeout), 32'd0);
    check("t5_period", period_cycles, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    check("t5_idle_busy", 32'(busy), 32'd0);
    check("t5_idle_valid", 32'(valid), 32'd0);

    // T6: period switches 100 -> 200 right after the second counted rise
    // Periods seen: 100 + 200 + 200 + 200 = 700 -> 175
    @(posedge sig_in);
    repeat (90) @(negedge clk);
    pulse_start();
    @(posedge sig_in);
    @(posedge sig_in);
    hi = 100; lo = 100;
    wait_valid(2000, cyc);
    check("t6_valid", 32'(valid), 32'd1);
    check("t6_timeout", 32'(timeout), 32'd0);
    check("t6_period", period_cycles, 32'd175);
    @(posedge sig_in);
    repeat (190) @(negedge clk);
    run_meas("t6_next", 32'd200, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
